// File: rtl/cp0_intr_regs_if.sv
// cp0_intr_regs_if: control-unit <-> CP0 bundle (strobes, operands in; intr, Status/Cause/EPC, next_pc, wb_data out)
interface cp0_intr_regs_if;
  logic        intr;
  logic        inta;
  logic        exc;
  logic        wsta;
  logic        wcau;
  logic        wepc;
  logic        mtc0;
  logic [1:0]  mfc0;
  logic [1:0]  selpc;
  logic [31:0] cause_in;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] res_in;
  logic [31:0] sta;
  logic [31:0] cau;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic [31:0] wb_data;
  modport master (
    input  intr, sta, cau, epc, next_pc, wb_data,
    output inta, exc, wsta, wcau, wepc, mtc0, mfc0, selpc, cause_in, wdata, pc, npc, res_in
  );
  modport slave (
    output intr, sta, cau, epc, next_pc, wb_data,
    input  inta, exc, wsta, wcau, wepc, mtc0, mfc0, selpc, cause_in, wdata, pc, npc, res_in
  );
endinterface

// File: rtl/cp0_intr_regs.sv
// cp0_intr_regs: Status/Cause/EPC with irq sync+edge latch, next_pc and mfc0 mux (clk, rst, i_irq_ext, cp slave bundle)
module cp0_intr_regs #(
  parameter logic [31:0] EXC_BASE  = 32'h0000_0008,
  parameter logic [31:0] STA_RESET = 32'h0000_000F
) (
  input  logic clk,
  input  logic rst,
  input  logic i_irq_ext,
  cp0_intr_regs_if.slave cp
);
  logic        r_s1, r_s2, r_s3, r_pend;
  logic [31:0] r_sta, r_cau, r_epc;
  logic        w_rise, w_eret;
  assign w_rise = r_s2 & ~r_s3;
  assign w_eret = (cp.selpc == 2'b01) & cp.wsta;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_pend <= 1'b0;
      r_sta  <= STA_RESET;
      r_cau  <= '0;
      r_epc  <= '0;
    end else begin
      r_s1   <= i_irq_ext;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_rise | (r_pend & ~cp.inta);
      r_sta  <= cp.exc ? {r_sta[27:0], 4'b0000} :
                w_eret ? {4'b0000, r_sta[31:4]} :
                (cp.wsta & cp.mtc0) ? cp.wdata : r_sta;
      r_cau  <= cp.exc ? cp.cause_in : (cp.wcau & cp.mtc0) ? cp.wdata : r_cau;
      r_epc  <= cp.exc ? ((cp.cause_in[3:2] == 2'b00) ? cp.npc : cp.pc) :
                (cp.wepc & cp.mtc0) ? cp.wdata : r_epc;
    end
  end
  always_comb begin
    cp.intr    = r_pend;
    cp.sta     = r_sta;
    cp.cau     = r_cau;
    cp.epc     = r_epc;
    cp.next_pc = cp.selpc[1] ? EXC_BASE : cp.selpc[0] ? r_epc : cp.npc;
    cp.wb_data = (cp.mfc0 == 2'b01) ? r_sta :
                 (cp.mfc0 == 2'b10) ? r_cau :
                 (cp.mfc0 == 2'b11) ? r_epc : cp.res_in;
  end
endmodule

// File: tb/tb_cp0_intr_regs.sv
// tb_cp0_intr_regs: directed self-checking bench for cp0_intr_regs
module tb_cp0_intr_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq = 1'b0;
  int total = 0;
  int bad = 0;
  cp0_intr_regs_if bus ();
  cp0_intr_regs dut (.clk(clk), .rst(rst), .i_irq_ext(irq), .cp(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic idle();
    bus.inta = 0; bus.exc = 0; bus.wsta = 0; bus.wcau = 0; bus.wepc = 0; bus.mtc0 = 0;
    bus.mfc0 = 0; bus.selpc = 0; bus.cause_in = 0; bus.wdata = 0;
  endtask
  task automatic test_reset();
    idle();
    bus.pc = 32'h0; bus.npc = 32'h1234; bus.res_in = 32'hABCD;
    rst = 1; tick(2); rst = 0; tick();
    chk("rst_sta", bus.sta, 32'hF);
    chk("rst_cau", bus.cau, 32'h0);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_intr", {31'b0, bus.intr}, 32'h0);
    chk("rst_next_pc", bus.next_pc, 32'h1234);
    bus.mfc0 = 2'b01; #1;
    chk("rst_wb_sta", bus.wb_data, 32'hF);
    bus.mfc0 = 2'b00; #1;
    chk("rst_wb_res", bus.wb_data, 32'hABCD);
  endtask
  task automatic test_intr();
    irq = 1;
    tick(2);
    chk("irq_lat2", {31'b0, bus.intr}, 32'h0);
    tick();
    chk("irq_lat3", {31'b0, bus.intr}, 32'h1);
    tick(3);
    chk("irq_hold", {31'b0, bus.intr}, 32'h1);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("irq_ack", {31'b0, bus.intr}, 32'h0);
    tick(4);
    chk("irq_level_no_retrig", {31'b0, bus.intr}, 32'h0);
    irq = 0; tick(4);
  endtask
  task automatic test_exc_taken();
    bus.exc = 1; bus.cause_in = 0; bus.pc = 32'h40; bus.npc = 32'h44; bus.selpc = 2'b10; #1;
    chk("exc_next_pc", bus.next_pc, 32'h8);
    tick(); idle();
    chk("exc_sta", bus.sta, 32'hF0);
    chk("exc_cau", bus.cau, 32'h0);
    chk("exc_epc", bus.epc, 32'h44);
    bus.selpc = 2'b01; bus.wsta = 1; bus.npc = 32'h999; #1;
    chk("eret_next_pc", bus.next_pc, 32'h44);
    tick(); idle();
    chk("eret_sta", bus.sta, 32'h0F);
  endtask
  task automatic test_overflow();
    bus.exc = 1; bus.cause_in = 32'hC; bus.pc = 32'h100; bus.npc = 32'h104;
    tick(); idle();
    chk("ovf_epc", bus.epc, 32'h100);
    chk("ovf_cau", bus.cau, 32'hC);
    chk("ovf_sta", bus.sta, 32'hF0);
    bus.mfc0 = 2'b10; #1;
    chk("ovf_wb_cau", bus.wb_data, 32'hC);
    idle();
  endtask
  task automatic test_mtc0();
    bus.mtc0 = 1; bus.wepc = 1; bus.wdata = 32'h200; bus.mfc0 = 2'b11; bus.selpc = 2'b01; #1;
    chk("mtc0_no_fwd_wb", bus.wb_data, 32'h100);
    chk("mtc0_no_fwd_pc", bus.next_pc, 32'h100);
    tick();
    chk("mtc0_epc", bus.epc, 32'h200);
    bus.selpc = 0;
    bus.exc = 1; bus.cause_in = 32'h4; bus.pc = 32'h50; bus.npc = 32'h54;
    tick(); idle();
    chk("mtc0_exc_epc", bus.epc, 32'h50);
    chk("mtc0_exc_cau", bus.cau, 32'h4);
    bus.wepc = 1; bus.wcau = 1; bus.wdata = 32'h999;
    tick(); idle();
    chk("ign_epc", bus.epc, 32'h50);
    chk("ign_cau", bus.cau, 32'h4);
    bus.mtc0 = 1; bus.wsta = 1; bus.wcau = 1; bus.wdata = 32'h5A;
    tick(); idle();
    chk("mtc0_sta", bus.sta, 32'h5A);
    chk("mtc0_cau", bus.cau, 32'h5A);
  endtask
  task automatic test_reset_priority();
    irq = 1; tick(3);
    chk("pre_rst_intr", {31'b0, bus.intr}, 32'h1);
    rst = 1; bus.exc = 1; bus.cause_in = 32'hC; bus.pc = 32'h300;
    tick(); rst = 0; idle();
    chk("rstp_sta", bus.sta, 32'hF);
    chk("rstp_cau", bus.cau, 32'h0);
    chk("rstp_epc", bus.epc, 32'h0);
    chk("rstp_intr", {31'b0, bus.intr}, 32'h0);
    irq = 0; tick(4);
    irq = 1; tick(); irq = 0; rst = 1; tick(); rst = 0;
    tick(4);
    chk("rst_discard_inflight", {31'b0, bus.intr}, 32'h0);
  endtask
  task automatic test_back_to_back();
    irq = 1; tick(3);
    chk("b2b_pend", {31'b0, bus.intr}, 32'h1);
    irq = 0; tick(4);
    chk("b2b_still_pend", {31'b0, bus.intr}, 32'h1);
    irq = 1; tick(2);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("b2b_edge_with_inta", {31'b0, bus.intr}, 32'h1);
    tick(2);
    chk("b2b_hold", {31'b0, bus.intr}, 32'h1);
    bus.inta = 1; tick(); bus.inta = 0;
    chk("b2b_final_ack", {31'b0, bus.intr}, 32'h0);
  endtask
  initial begin
    test_reset();
    test_intr();
    test_exc_taken();
    test_overflow();
    test_mtc0();
    test_reset_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_intr_regs.md
Name: cp0_intr_regs

Overview:
Coprocessor-0 state block that sits beside the interrupt-aware control unit of the single-cycle CPU. It holds the Status, Cause and EPC registers, which are written under the control unit's wsta/wcau/wepc/mtc0/selpc strobes. It synchronises and latches the external interrupt request into the level `intr` that the control unit consumes, and clears it on `inta`. It also produces the next PC and the mfc0 write-back data.

Parameters:
EXC_BASE, 32'h0000_0008, exception/interrupt handler entry address
STA_RESET, 32'h0000_000F, Status value after reset (all four enables set)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
irq_ext  in  1  raw external interrupt request, asynchronous to clk
intr  out  1  latched pending interrupt, to control unit
inta  in  1  interrupt acknowledge from control unit
exc  in  1  interrupt/exception taken this cycle
wsta  in  1  Status write enable
wcau  in  1  Cause write enable
wepc  in  1  EPC write enable
mtc0  in  1  current instruction is mtc0
mfc0  in  2  read select: 00 res_in, 01 Status, 10 Cause, 11 EPC
selpc  in  2  00 npc, 01 EPC (eret), 1x EXC_BASE
cause_in  in  32  Cause value computed by control unit, {28'h0, ExcCode[1:0], 2'b00}
wdata  in  32  rt register value for mtc0
pc  in  32  PC of current instruction
npc  in  32  normal next PC (pc+4/branch/jump)
res_in  in  32  normal ALU/memory write-back value
sta  out  32  Status register
cau  out  32  Cause register
epc  out  32  EPC register
next_pc  out  32  selected next PC
wb_data  out  32  register-file write data

Behaviour:
- Reset when rst=1 at a clk edge. Resulting values: sta=STA_RESET, cau=0, epc=0, sync flops=0, edge-history flop=0, pending=0, so intr=0.
- Interrupt input:
  - Two-flop synchroniser, then a rising-edge detector: rise = s2 & ~s3.
  - pending_next = rise | (pending & ~inta). A new edge in the same cycle as inta keeps pending=1.
  - intr = pending, registered. From an irq_ext rising edge meeting setup, intr rises after 3 clk edges.
  - A level held high does not re-trigger. irq_ext must go low and high again.
- Status update, priority exc > eret > mtc0:
  - exc=1: sta <= {sta[27:0], 4'b0000}. The old enables are saved in [7:4] and all enables are cleared.
  - selpc==01 (eret, wsta=1): sta <= {4'b0000, sta[31:4]}.
  - wsta & mtc0 & ~exc: sta <= wdata.
  - Otherwise sta holds.
- Cause update:
  - exc=1: cau <= cause_in.
  - wcau & mtc0 & ~exc: cau <= wdata.
  - Otherwise cau holds.
- EPC update:
  - exc=1 with cause_in[3:2]==00 (external interrupt): epc <= npc. The current instruction completes.
  - exc=1 with any other ExcCode (syscall, unimplemented, overflow): epc <= pc.
  - wepc & mtc0 & ~exc: epc <= wdata.
  - Otherwise epc holds.
- next_pc is combinational:
  - selpc[1]=1 gives EXC_BASE.
  - selpc==01 gives epc, the registered value; an EPC write in the same cycle is not forwarded.
  - selpc==00 gives npc.
- wb_data is combinational, selected by mfc0. It returns register values as of the start of the cycle; there is no write-through.
- wsta/wcau/wepc asserted with mtc0=0 and exc=0 are ignored, except the eret case above.
- Reset mid-operation: rst overrides every write and the interrupt latch in the same edge. An irq edge in flight in the synchroniser is discarded.

Test Plan:
- Reset, then idle: sta=0000_000F, cau=0, epc=0, intr=0, next_pc=npc. With mfc0=01, wb_data=0000_000F.
- Interrupt handshake: pulse irq_ext high and hold it high. intr=1 after 3 edges and stays 1 while inta=0. Assert inta one cycle and intr=0 next cycle. While irq_ext stays high, intr stays 0.
- Interrupt taken:
  - Stimulus: sta=F, exc=1, cause_in=0, pc=0x40, npc=0x44.
  - Response: next_pc=0x08 that cycle. After the edge, sta=0xF0, cau=0, epc=0x44.
  - Then selpc=01 with wsta=1: next_pc=0x44, and after the edge sta=0x0F.
- Overflow exception: exc=1, cause_in=0xC, pc=0x100 -> epc=0x100, cau=0xC. With mfc0=10, wb_data=0xC on the next cycle.
- mtc0 writes: mtc0=1, wepc=1, wdata=0x200 -> epc=0x200. The same mtc0 with exc=1, cause_in=0x4, pc=0x50 -> exc wins, epc=0x50, cau=0x4.
- Reset priority and same-cycle edge:
  - rst=1 together with exc=1 -> all registers return to reset values.
  - An irq rising edge in the same cycle as inta on a pending interrupt leaves intr=1.
